// File: rtl/ifetch32_unit_pkg.sv
// Shared definitions for the instruction-fetch stage:
// decode constants, fetch FSM states and next-PC control bundle.
package ifetch32_unit_pkg;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic jr;
        logic jmp;
        logic jal;
        logic branch;
        logic nbranch;
    } pc_ctrl_t;

endpackage

// File: rtl/ifetch32_unit_next_pc_sel.sv
// Next-PC target mux with word-alignment enforcement.
// Jr outranks jumps, which outrank taken branches.
import ifetch32_unit_pkg::*;

module ifetch32_unit_next_pc_sel (
    input  pc_ctrl_t    ctrl,
    input  logic        zero,
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic [31:0] read_data_1,
    input  logic [31:0] addr_result,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic        take_branch;
    logic [31:0] target;

    assign take_branch = (ctrl.branch & zero) | (ctrl.nbranch & ~zero);

    always_comb begin
        target = pc_plus4;
        priority case (1'b1)
            ctrl.jr:               target = read_data_1;
            ctrl.jmp | ctrl.jal:   target = {pc_plus4[31:28], instr_index, 2'b00};
            take_branch:           target = addr_result;
            default:               target = pc_plus4;
        endcase
    end

    assign next_pc    = {target[31:2], 2'b00};
    assign misaligned = |target[1:0];

endmodule

// File: rtl/ifetch32_unit.sv
// Instruction-fetch stage: PC register, prime/run/hold FSM and
// ROM address generation so rom_data always matches pc.
import ifetch32_unit_pkg::*;

module ifetch32_unit #(
    parameter int          ROM_AW   = 14,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       Instruction,
    output logic              instr_valid,
    output logic [31:0]       pc_out,
    output logic [31:0]       branch_base_addr,
    input  logic [31:0]       Addr_result,
    input  logic [31:0]       Read_data_1,
    input  logic              Zero,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jr,
    input  logic              stall,
    output logic [31:0]       link_addr,
    output logic              misalign_err
);

    fetch_state_t state;
    pc_ctrl_t     ctrl;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;
    logic         misaligned;
    logic         advance;

    assign pc_plus4         = pc + 32'd4;
    assign pc_out           = pc;
    assign branch_base_addr = pc_plus4;
    assign Instruction      = rom_data;

    assign ctrl = '{
        jr:      Jr,
        jmp:     Jmp,
        jal:     Jal,
        branch:  Branch,
        nbranch: nBranch
    };

    // PRIME covers the cycle where the ROM has not yet returned data for pc.
    assign instr_valid = !reset && (state != PRIME);
    assign advance     = instr_valid && !stall;

    ifetch32_unit_next_pc_sel u_next_pc_sel (
        .ctrl        (ctrl),
        .zero        (Zero),
        .pc_plus4    (pc_plus4),
        .instr_index (rom_data[25:0]),
        .read_data_1 (Read_data_1),
        .addr_result (Addr_result),
        .next_pc     (next_pc),
        .misaligned  (misaligned)
    );

    // Address the PC that will be current after the edge.
    always_comb begin
        rom_addr = pc[ROM_AW+1:2];
        if (reset) begin
            rom_addr = RESET_PC[ROM_AW+1:2];
        end else if (advance) begin
            rom_addr = next_pc[ROM_AW+1:2];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc           <= RESET_PC;
            state        <= PRIME;
            link_addr    <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            unique case (state)
                PRIME: begin
                    state <= RUN;
                end
                RUN, HOLD: begin
                    if (stall) begin
                        state <= HOLD;
                    end else begin
                        state <= RUN;
                        pc    <= next_pc;
                        if (Jal) begin
                            link_addr <= pc_plus4;
                        end
                        if (misaligned) begin
                            misalign_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= PRIME;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch32_unit.sv
// Scoreboard bench for ifetch32_unit: expected PC/instruction pairs
// are queued when controls are driven and popped after the edge.
import ifetch32_unit_pkg::*;

module tb_ifetch32_unit;

    logic        clock;
    logic        reset;
    logic [13:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] branch_base_addr;
    logic [31:0] Addr_result;
    logic [31:0] Read_data_1;
    logic        Zero;
    logic        Branch;
    logic        nBranch;
    logic        Jmp;
    logic        Jal;
    logic        Jr;
    logic        stall;
    logic [31:0] link_addr;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [0:16383];

    typedef struct {
        logic        jr;
        logic        jmp;
        logic        jal;
        logic        br;
        logic        nbr;
        logic        z;
        logic        stl;
        logic [31:0] rd1;
        logic [31:0] ar;
        logic [31:0] exp;
    } step_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];

    ifetch32_unit #(
        .ROM_AW   (14),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .Instruction      (Instruction),
        .instr_valid      (instr_valid),
        .pc_out           (pc_out),
        .branch_base_addr (branch_base_addr),
        .Addr_result      (Addr_result),
        .Read_data_1      (Read_data_1),
        .Zero             (Zero),
        .Branch           (Branch),
        .nBranch          (nBranch),
        .Jmp              (Jmp),
        .Jal              (Jal),
        .Jr               (Jr),
        .stall            (stall),
        .link_addr        (link_addr),
        .misalign_err     (misalign_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_addr];

    function automatic step_t mk(
        input logic jr, jmp, jal, br, nbr, z, stl,
        input logic [31:0] rd1, ar, exp
    );
        step_t s;
        s.jr  = jr;
        s.jmp = jmp;
        s.jal = jal;
        s.br  = br;
        s.nbr = nbr;
        s.z   = z;
        s.stl = stl;
        s.rd1 = rd1;
        s.ar  = ar;
        s.exp = exp;
        return s;
    endfunction

    function automatic step_t go(input logic [31:0] a);
        return mk(1, 0, 0, 0, 0, 0, 0, a, 0, a);
    endfunction

    function automatic step_t seq(input logic [31:0] e);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, e);
    endfunction

    task automatic apply(input step_t s);
        exp_t e;
        Jr          = s.jr;
        Jmp         = s.jmp;
        Jal         = s.jal;
        Branch      = s.br;
        nBranch     = s.nbr;
        Zero        = s.z;
        stall       = s.stl;
        Read_data_1 = s.rd1;
        Addr_result = s.ar;
        e.pc        = s.exp;
        e.instr     = rom[s.exp[15:2]];
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_iv: got %b expected 0", instr_valid);
        end
        checks++;
        if (rom_addr !== 14'd0) begin
            errors++;
            $display("FAIL reset_rom_addr: got %h expected 0", rom_addr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL prime_iv: got %b expected 0", instr_valid);
        end
        checks++;
        if (rom_addr !== 14'd0) begin
            errors++;
            $display("FAIL prime_rom_addr: got %h expected 0", rom_addr);
        end
        @(negedge clock);
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL run_iv: got %b expected 1", instr_valid);
        end
        checks++;
        if (pc_out !== 32'h0) begin
            errors++;
            $display("FAIL run_pc: got %h expected 0", pc_out);
        end
        checks++;
        if (Instruction !== rom[0]) begin
            errors++;
            $display("FAIL run_instr: got %h expected %h", Instruction, rom[0]);
        end
    endtask

    task automatic test_sequential();
        step_t s[$];
        exp_t  e;
        s.push_back(seq(32'h4));
        s.push_back(seq(32'h8));
        s.push_back(seq(32'hC));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (pc_out !== e.pc) begin
                errors++;
                $display("FAIL seq[%0d] pc: got %h expected %h", i, pc_out, e.pc);
            end
            checks++;
            if (Instruction !== e.instr) begin
                errors++;
                $display("FAIL seq[%0d] instr: got %h expected %h", i, Instruction, e.instr);
            end
            checks++;
            if (branch_base_addr !== e.pc + 32'd4) begin
                errors++;
                $display("FAIL seq[%0d] pc4: got %h expected %h", i, branch_base_addr, e.pc + 32'd4);
            end
        end
    endtask

    task automatic test_branch();
        step_t s[$];
        exp_t  e;
        s.push_back(go(32'h10));
        s.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 32'h40, 32'h40));
        s.push_back(go(32'h10));
        s.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h40, 32'h14));
        s.push_back(go(32'h10));
        s.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h40, 32'h40));
        s.push_back(go(32'h10));
        s.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 32'h40, 32'h14));
        s.push_back(mk(1, 0, 0, 1, 0, 1, 0, 32'h80, 32'h40, 32'h80));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (pc_out !== e.pc) begin
                errors++;
                $display("FAIL br[%0d] pc: got %h expected %h", i, pc_out, e.pc);
            end
            checks++;
            if (Instruction !== e.instr) begin
                errors++;
                $display("FAIL br[%0d] instr: got %h expected %h", i, Instruction, e.instr);
            end
        end
    endtask

    task automatic test_jal_jr();
        step_t       s[$];
        exp_t        e;
        logic [31:0] lk[$];
        s.push_back(go(32'h20));
        lk.push_back(32'h0);
        s.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h40));
        lk.push_back(32'h24);
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h24, 0, 32'h24));
        lk.push_back(32'h24);
        s.push_back(go(32'hF000_0020));
        lk.push_back(32'h24);
        s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hF000_0040));
        lk.push_back(32'h24);
        s.push_back(go(32'hFFFF_FFFC));
        lk.push_back(32'h24);
        s.push_back(seq(32'h0));
        lk.push_back(32'h24);
        s.push_back(go(32'h20));
        lk.push_back(32'h24);
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (pc_out !== e.pc) begin
                errors++;
                $display("FAIL jal[%0d] pc: got %h expected %h", i, pc_out, e.pc);
            end
            checks++;
            if (Instruction !== e.instr) begin
                errors++;
                $display("FAIL jal[%0d] instr: got %h expected %h", i, Instruction, e.instr);
            end
            checks++;
            if (link_addr !== lk[i]) begin
                errors++;
                $display("FAIL jal[%0d] link: got %h expected %h", i, link_addr, lk[i]);
            end
        end
    endtask

    task automatic test_stall();
        step_t s[$];
        exp_t  e;
        s.push_back(go(32'h8));
        for (int k = 0; k < 3; k++) begin
            s.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 32'h8));
        end
        s.push_back(seq(32'hC));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (pc_out !== e.pc) begin
                errors++;
                $display("FAIL stall[%0d] pc: got %h expected %h", i, pc_out, e.pc);
            end
            checks++;
            if (Instruction !== e.instr) begin
                errors++;
                $display("FAIL stall[%0d] instr: got %h expected %h", i, Instruction, e.instr);
            end
            checks++;
            if (instr_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall[%0d] iv: got %b expected 1", i, instr_valid);
            end
            checks++;
            if (link_addr !== 32'h24) begin
                errors++;
                $display("FAIL stall[%0d] link: got %h expected 24", i, link_addr);
            end
            if (s[i].stl) begin
                checks++;
                if (rom_addr !== 14'd2) begin
                    errors++;
                    $display("FAIL stall[%0d] rom_addr: got %h expected 2", i, rom_addr);
                end
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_misalign();
        step_t s[$];
        exp_t  e;
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL mis_pre: got %b expected 0", misalign_err);
        end
        s.push_back(go(32'h0000_0042));
        s[0].exp = 32'h40;
        s.push_back(seq(32'h44));
        s.push_back(go(32'h30));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clock);
            e = exp_q.pop_front();
            checks++;
            if (pc_out !== e.pc) begin
                errors++;
                $display("FAIL mis[%0d] pc: got %h expected %h", i, pc_out, e.pc);
            end
            checks++;
            if (misalign_err !== 1'b1) begin
                errors++;
                $display("FAIL mis[%0d] err: got %b expected 1", i, misalign_err);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        apply(mk(0, 0, 1, 0, 0, 1, 1, 0, 32'h40, 32'h30));
        Branch = 1'b1;
        @(negedge clock);
        e = exp_q.pop_front();
        checks++;
        if (pc_out !== e.pc) begin
            errors++;
            $display("FAIL rst_stall pc: got %h expected %h", pc_out, e.pc);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (pc_out !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid pc: got %h expected 0", pc_out);
        end
        checks++;
        if (link_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid link: got %h expected 0", link_addr);
        end
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid err: got %b expected 0", misalign_err);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid prime_iv: got %b expected 0", instr_valid);
        end
        @(negedge clock);
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid run_iv: got %b expected 1", instr_valid);
        end
        checks++;
        if (pc_out !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid run_pc: got %h expected 0", pc_out);
        end
        checks++;
        if (Instruction !== rom[0]) begin
            errors++;
            $display("FAIL rst_mid instr: got %h expected %h", Instruction, rom[0]);
        end
        stall  = 1'b0;
        Jal    = 1'b0;
        Branch = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            rom[i] = 32'hA500_0000 + 32'(i);
        end
        rom[8] = {OP_JAL, 26'h10};
        reset       = 1'b1;
        Addr_result = 32'h0;
        Read_data_1 = 32'h0;
        Zero        = 1'b0;
        Branch      = 1'b0;
        nBranch     = 1'b0;
        Jmp         = 1'b0;
        Jal         = 1'b0;
        Jr          = 1'b0;
        stall       = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_jal_jr();
        test_stall();
        test_misalign();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
